// File: rtl/seg7_scan_driver.sv
// Four-digit hex 7-segment scan driver.
// Latches bus writes, commits them only at frame boundaries, and time-multiplexes
// the decoded digits onto a shared {an[3:0], seg[7:0]} active-low word.
module seg7_scan_driver #(
    parameter int unsigned SCAN_DIV     = 100000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    output logic        pending,
    output logic        frame_done,
    output logic [11:0] digital
);

    localparam int unsigned CNT_W = $clog2(SCAN_DIV);

    generate
        if (SCAN_DIV < 4) begin : g_bad_scan_div
            $error("seg7_scan_driver: SCAN_DIV must be >= 4");
        end
        if (BLANK_CYCLES < 1 || BLANK_CYCLES > SCAN_DIV - 2) begin : g_bad_blank
            $error("seg7_scan_driver: BLANK_CYCLES must be in 1..SCAN_DIV-2");
        end
    endgenerate

    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    logic [23:0]      pend_data;
    logic [23:0]      shadow;
    logic             slot_end;
    logic             boundary;
    logic [11:0]      digital_next;

    // Top byte of the bus word carries nothing for this block.
    logic unused_wr_data;
    assign unused_wr_data = ^wr_data[31:24];

    // Shadow layout mirrors wr_data[23:0].
    logic [15:0] shadow_val;
    logic [3:0]  shadow_dp;
    logic [3:0]  shadow_en;
    assign shadow_val = shadow[15:0];
    assign shadow_dp  = shadow[19:16];
    assign shadow_en  = shadow[23:20];

    assign slot_end = (cnt == CNT_W'(SCAN_DIV - 1));
    assign boundary = slot_end && (idx == 2'd3);

    // Active-low gfedcba pattern for one hex nibble.
    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] s;
        unique case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Slot prescaler and digit index; idx wraps naturally at 2 bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            idx <= 2'd0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= idx + 2'd1;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Registered pulse lands on the first cycle of the next frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= boundary;
        end
    end

    // Writes park in pend_data; only the boundary cycle updates the displayed shadow,
    // and a write landing exactly on the boundary bypasses the older pending value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_data <= '0;
            shadow    <= '0;
            pending   <= 1'b0;
        end else if (boundary) begin
            if (wr_en) begin
                shadow  <= wr_data[23:0];
                pending <= 1'b0;
            end else if (pending) begin
                shadow  <= pend_data;
                pending <= 1'b0;
            end
        end else if (wr_en) begin
            pend_data <= wr_data[23:0];
            pending   <= 1'b1;
        end
    end

    // Dark during the blank window or for disabled digits; otherwise drive one anode.
    always_comb begin
        digital_next = 12'hFFF;
        if (cnt >= CNT_W'(BLANK_CYCLES) && shadow_en[idx]) begin
            digital_next = {~(4'b0001 << idx), ~shadow_dp[idx],
                            hex_decode(shadow_val[{idx, 2'b00} +: 4])};
        end
    end

    // One-cycle registered output stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digital <= 12'hFFF;
        end else begin
            digital <= digital_next;
        end
    end

endmodule
